fifo_wr_packer: RTL
===================

Name: fifo_wr_packer

Overview:
Write-side producer for the async dual-clock fifo (DWID=32, AWID=10). It accepts an 8-bit byte stream with valid/ready/last handshake and packs bytes little-endian into DWID-bit words. It drives WRENA/WRDAT and uses WRLEV for backpressure. It sits in the wrclk domain upstream of the fifo, and the HDMI-side reader drains the fifo in rdclk.

Parameters:
DWID, 32, fifo word width; must be a multiple of 8, range 16..64
AWID, 10, fifo address width; depth = 2**AWID
AFULL_THR, 1016, in_ready drops when fifo_wrlev >= AFULL_THR; must be <= 2**AWID-4

Ports:
wrclk  in  1  write-domain clock
rst  in  1  reset, synchronous, active-low
in_valid  in  1  byte valid
in_ready  out  1  byte accepted when in_valid && in_ready
in_data  in  8  byte payload
in_last  in  1  last byte of packet; forces partial-word flush
fifo_wrena  out  1  to fifo WRENA
fifo_wrdat  out  DWID  to fifo WRDAT
fifo_wrlev  in  AWID  from fifo WRLEV
word_cnt  out  16  words written since reset, wraps at 16'hFFFF->0
ovf_err  out  1  sticky overflow flag (see Optional Feature)

Behaviour:
- Reset is sampled on wrclk, active when rst==0. Values during reset: in_ready=0, fifo_wrena=0, fifo_wrdat=0, word_cnt=0, ovf_err=0, lane=0, shift register=0, state=S_FILL.
- LANES = DWID/8. lane counter width is clog2(LANES).
- space_ok register: updated every cycle as space_ok <= (fifo_wrlev < AFULL_THR). in_ready = space_ok && (state==S_FILL). in_ready is a pure function of registers; it never combinationally depends on in_valid.
- S_FILL, on accept:
  - byte goes to lane index lane; bits [8*lane+7:8*lane] of the accumulator.
  - If lane==LANES-1 or in_last==1: next cycle fifo_wrena=1 and fifo_wrdat = accumulator with the new byte included. Lanes above lane are zero when in_last ends a partial word. lane resets to 0 and the accumulator clears.
  - Otherwise lane increments.
- Write latency: exactly 1 cycle from the completing accept to fifo_wrena high. fifo_wrena is high for one cycle per word. fifo_wrdat holds its value until the next write.
- S_HOLD: entered when a word completes on the same cycle space_ok==0 would be violated. Concretely, if fifo_wrlev >= 2**AWID-2 when a word is due, the word is held in an output register and state=S_HOLD with in_ready=0. The held word is written on the first cycle fifo_wrlev < 2**AWID-2, then state returns to S_FILL.
- Back-to-back: with no backpressure the block sustains 1 byte/cycle, i.e. one word every LANES cycles. A flush on in_last followed by an immediate next byte is allowed with no bubble.
- word_cnt increments on every cycle fifo_wrena==1.
- in_last on a lane==LANES-1 byte produces one full word, not an extra empty word.
- in_valid with in_ready==0: the byte is not consumed, and upstream must hold it stable.
- Reset mid-packet: the partial accumulator is discarded and no flush word is written.

Optional Feature:
Macro FIFO_WR_OVF_CHECK_EN.
- Defined: at the write cycle, if fifo_wrlev == 2**AWID-1, fifo_wrena is suppressed, the word is dropped, word_cnt is not incremented, and ovf_err is set sticky until reset. The S_HOLD mechanism still applies; this is a second line of defence.
- Undefined: ovf_err is tied 0 and the write is unconditional once issued.

Decomposition:
- Package fifo_wr_pkg holds:
  - typedef enum logic [0:0] {S_FILL, S_HOLD} wr_state_t;
  - function lanes(int dwid) returning dwid/8;
  - localparam WORD_CNT_W = 16.
- One sub-module is natural: byte_lane_acc. It is the lane counter plus accumulator with a clear/flush output; the FSM and the fifo interface stay in the top level.

Test Plan:
1. Reset release, in_valid=1, bytes 0x01..0x08, fifo_wrlev=0 -> fifo_wrdat=0x04030201 then 0x08070605, each 1 cycle after the 4th/8th accept; word_cnt=2.
2. Bytes 0xAA,0xBB with in_last on 0xBB -> single write 0x0000BBAA; lane returns 0; next byte 0x11 lands in lane 0.
3. fifo_wrlev forced to 1016 -> in_ready=0 one cycle later; no accepts; drop to 1015 -> in_ready=1 next cycle.
4. Word completes while fifo_wrlev=1022 -> state S_HOLD, no write; fifo_wrlev=1020 -> write occurs that cycle+1, data intact.
5. With FIFO_WR_OVF_CHECK_EN, fifo_wrlev=1023 at write -> fifo_wrena=0, ovf_err=1 sticky, word_cnt unchanged; without the macro -> write issued, ovf_err=0.
6. rst=0 after 3 of 4 bytes, then release -> no write emitted, outputs at reset values, next 4 bytes form a clean word.

Source files
------------

// File: rtl/fifo_wr_pkg.sv
// Shared types and helpers for the fifo write-side byte packer.
package fifo_wr_pkg;

   typedef enum logic [0:0] {S_FILL, S_HOLD} wr_state_t;

   localparam int WORD_CNT_W = 16;

   function automatic int lanes(int dwid);
      return dwid / 8;
   endfunction

endpackage

// File: rtl/byte_lane_acc.sv
// Lane counter plus little-endian accumulator. Presents the word with the
// current byte merged in, and flags completion on the last lane or in_last.
import fifo_wr_pkg::*;

module byte_lane_acc #(
   parameter int DWID = 32
) (
   input  logic            wrclk,
   input  logic            rst,
   input  logic            accept,
   input  logic [7:0]      in_data,
   input  logic            in_last,
   output logic            word_done,
   output logic [DWID-1:0] word
);

   localparam int LANES  = lanes(DWID);
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

   logic [LANE_W-1:0] lane;
   logic [DWID-1:0]   acc;

   // Merge the incoming byte into its lane; untouched upper lanes stay zero
   always_comb begin
      word = acc;
      for (int i = 0; i < LANES; i++) begin
         if (lane == LANE_W'(i)) begin
            word[8*i +: 8] = in_data;
         end
      end
   end

   assign word_done = accept && (in_last || (lane == LAST_LANE));

   // Advance the lane on each accept; clear everything once a word leaves
   always_ff @(posedge wrclk) begin
      if (!rst) begin
         lane <= '0;
         acc  <= '0;
      end else if (accept) begin
         if (word_done) begin
            lane <= '0;
            acc  <= '0;
         end else begin
            lane <= lane + 1'b1;
            acc  <= word;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_packer.sv
// Write-side producer for the dual-clock fifo: packs a byte stream into
// DWID-bit words and writes them, throttled by the fifo write level.
// Optional build macro FIFO_WR_OVF_CHECK_EN suppresses a write that would
// land on a completely full fifo and raises the sticky ovf_err flag.
import fifo_wr_pkg::*;

module fifo_wr_packer #(
   parameter int DWID      = 32,
   parameter int AWID      = 10,
   parameter int AFULL_THR = 1016
) (
   input  logic                  wrclk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [7:0]            in_data,
   input  logic                  in_last,
   output logic                  fifo_wrena,
   output logic [DWID-1:0]       fifo_wrdat,
   input  logic [AWID-1:0]       fifo_wrlev,
   output logic [WORD_CNT_W-1:0] word_cnt,
   output logic                  ovf_err
);

   localparam logic [AWID-1:0] AFULL_LEV = AWID'(AFULL_THR);
   localparam logic [AWID-1:0] HOLD_LEV  = AWID'((2**AWID) - 2);

   wr_state_t       state_q;
   wr_state_t       state_d;
   logic            space_ok;
   logic            accept;
   logic            word_done;
   logic [DWID-1:0] acc_word;
   logic            issue;
   logic [DWID-1:0] issue_word;
   logic            hold_load;
   logic [DWID-1:0] hold_word;
   logic            wr_req;

   assign in_ready = space_ok && (state_q == S_FILL);
   assign accept   = in_valid && in_ready;

   byte_lane_acc #(
      .DWID (DWID)
   ) u_acc (
      .wrclk     (wrclk),
      .rst       (rst),
      .accept    (accept),
      .in_data   (in_data),
      .in_last   (in_last),
      .word_done (word_done),
      .word      (acc_word)
   );

   // Registered almost-full view so in_ready never depends on this cycle's inputs
   always_ff @(posedge wrclk) begin
      if (!rst) begin
         space_ok <= 1'b0;
      end else begin
         space_ok <= (fifo_wrlev < AFULL_LEV);
      end
   end

   // FSM state register
   always_ff @(posedge wrclk) begin
      if (!rst) begin
         state_q <= S_FILL;
      end else begin
         state_q <= state_d;
      end
   end

   // Decide whether a finished word is written now or parked until the fifo drains
   always_comb begin
      state_d    = state_q;
      issue      = 1'b0;
      issue_word = acc_word;
      hold_load  = 1'b0;
      case (state_q)
         S_FILL: begin
            if (word_done) begin
               if (fifo_wrlev >= HOLD_LEV) begin
                  state_d   = S_HOLD;
                  hold_load = 1'b1;
               end else begin
                  issue = 1'b1;
               end
            end
         end
         S_HOLD: begin
            if (fifo_wrlev < HOLD_LEV) begin
               state_d    = S_FILL;
               issue      = 1'b1;
               issue_word = hold_word;
            end
         end
         default: state_d = S_FILL;
      endcase
   end

   // Output and hold registers; write data only changes when a write is issued
   always_ff @(posedge wrclk) begin
      if (!rst) begin
         wr_req     <= 1'b0;
         fifo_wrdat <= '0;
         hold_word  <= '0;
      end else begin
         wr_req <= issue;
         if (issue) begin
            fifo_wrdat <= issue_word;
         end
         if (hold_load) begin
            hold_word <= acc_word;
         end
      end
   end

   // Count every cycle the fifo actually sees a write strobe
   always_ff @(posedge wrclk) begin
      if (!rst) begin
         word_cnt <= '0;
      end else if (fifo_wrena) begin
         word_cnt <= word_cnt + 1'b1;
      end
   end

`ifdef FIFO_WR_OVF_CHECK_EN
   localparam logic [AWID-1:0] FULL_LEV = '1;

   assign fifo_wrena = wr_req && (fifo_wrlev != FULL_LEV);

   // Sticky record of a write that had to be dropped on a full fifo
   always_ff @(posedge wrclk) begin
      if (!rst) begin
         ovf_err <= 1'b0;
      end else if (wr_req && (fifo_wrlev == FULL_LEV)) begin
         ovf_err <= 1'b1;
      end
   end
`else
   assign fifo_wrena = wr_req;
   assign ovf_err    = 1'b0;
`endif

endmodule
